// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice: operand widths and shift op encoding.
package shift_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SHAMT_W = 4;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b01;
  localparam shift_op_t OP_SRA = 2'b10;
  localparam shift_op_t OP_ROR = 2'b11;

endpackage

// File: rtl/shift_core.sv
// Purely combinational 16-bit shifter: logical left/right, arithmetic right, rotate right.
module shift_core
  import shift_pkg::*;
(
  input  shift_op_t            op,
  input  logic [DATA_W-1:0]    data,
  input  logic [SHAMT_W-1:0]   shamt,
  output logic [DATA_W-1:0]    result
);

  always_comb begin
    result = data;
    unique case (op)
      OP_SLL:  result = data << shamt;
      OP_SRL:  result = data >> shamt;
      OP_SRA:  result = DATA_W'($signed(data) >>> shamt);
      // Low half of the doubled word shifted right is the rotation.
      OP_ROR:  result = DATA_W'({data, data} >> shamt);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between NREQ requesters through a two-stage
// (operand, result) pipeline with valid/ready backpressure on the response side.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [DATA_W*NREQ-1:0]    req_data,
  input  logic [SHAMT_W*NREQ-1:0]   req_shamt,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [IDW-1:0]            rsp_id
);

  logic [IDW-1:0]     rr_q, rr_d;
  logic [IDW-1:0]     win_id;
  logic [IDW-1:0]     scan_idx;
  logic               win_found;
  logic               grant;

  logic               a_v_q, a_v_d;
  shift_op_t          a_op_q;
  logic [DATA_W-1:0]  a_data_q;
  logic [SHAMT_W-1:0] a_shamt_q;
  logic [IDW-1:0]     a_id_q;

  logic               b_v_q, b_v_d;
  logic [DATA_W-1:0]  b_data_q;
  logic [IDW-1:0]     b_id_q;

  logic               a_adv, b_adv;
  logic [DATA_W-1:0]  core_result;

  assign b_adv = !b_v_q || rsp_ready;
  assign a_adv = a_v_q && b_adv;

  // Scan downward so the requester closest to rr (upward, wrapping) is written last and wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      scan_idx = IDW'((32'(rr_q) + 32'(k)) % NREQ);
      if (req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Gating with rst_n keeps req_ready low for the whole reset window, not just after an edge.
  assign grant = rst_n && win_found && (!a_v_q || a_adv);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (32'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
    a_v_d = grant || (a_v_q && !a_adv);
    b_v_d = b_adv ? a_v_q : b_v_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      a_v_q     <= 1'b0;
      a_op_q    <= OP_SLL;
      a_data_q  <= '0;
      a_shamt_q <= '0;
      a_id_q    <= '0;
      b_v_q     <= 1'b0;
      b_data_q  <= '0;
      b_id_q    <= '0;
    end else begin
      rr_q  <= rr_d;
      a_v_q <= a_v_d;
      b_v_q <= b_v_d;
      if (grant) begin
        a_op_q    <= req_op[32'(win_id) * 2 +: 2];
        a_data_q  <= req_data[32'(win_id) * DATA_W +: DATA_W];
        a_shamt_q <= req_shamt[32'(win_id) * SHAMT_W +: SHAMT_W];
        a_id_q    <= win_id;
      end
      if (a_adv) begin
        b_data_q <= core_result;
        b_id_q   <= a_id_q;
      end
    end
  end

  shift_core u_shift_core (
    .op     (a_op_q),
    .data   (a_data_q),
    .shamt  (a_shamt_q),
    .result (core_result)
  );

  assign rsp_valid = b_v_q;
  assign rsp_data  = b_data_q;
  assign rsp_id    = b_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations on grant order, results and latency.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [16*NREQ-1:0] req_data;
  logic [4*NREQ-1:0] req_shamt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;

  shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-requester pending request lists; head entry is what the requester presents.
  logic [1:0]  p_op   [NREQ][64];
  logic [15:0] p_data [NREQ][64];
  logic [3:0]  p_sh   [NREQ][64];
  int hd[NREQ];
  int tl[NREQ];
  logic [NREQ-1:0] gnt_seen;

  // Reference model: in-flight results in order, with the cycle each was granted.
  typedef struct {
    int          id;
    logic [15:0] res;
    int          gcyc;
  } ent_t;
  ent_t mq[$];
  int   m_rr;

  int gq_id[$];
  int gq_cyc[$];
  int rq_id[$];
  int rq_data[$];
  int rq_cyc[$];

  function automatic logic [15:0] mshift(input logic [1:0] op, input logic [15:0] d,
                                          input logic [3:0] s);
    logic [31:0] x;
    int n;
    x = {16'h0, d};
    n = int'(s);
    case (op)
      2'd0: x = x << n;
      2'd1: x = x >> n;
      2'd2: begin
        if (d[15]) x = x | 32'hFFFF_0000;
        x = x >> n;
      end
      default: x = (x >> n) | (x << (16 - n));
    endcase
    return x[15:0];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: outputs are checked mid-cycle, then the model takes its step.
  initial begin
    int   w;
    bit   found;
    bit   vis;
    bit   drain;
    bit   can;
    logic [NREQ-1:0] exp_ready;
    ent_t e;
    m_rr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        mq.delete();
        m_rr = 0;
        gnt_seen = '0;
      end else begin
        vis = (mq.size() > 0) && (cyc - mq[0].gcyc >= 2);
        chk("rsp_valid", 32'(rsp_valid), 32'(vis));
        if (vis) begin
          chk("rsp_data", 32'(rsp_data), 32'(mq[0].res));
          chk("rsp_id", 32'(rsp_id), 32'(mq[0].id));
        end
        drain = vis && rsp_ready;
        found = 1'b0;
        w = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && req_valid[(m_rr + k) % NREQ]) begin
            found = 1'b1;
            w = (m_rr + k) % NREQ;
          end
        end
        can = (mq.size() - int'(drain)) < 2;
        exp_ready = '0;
        if (found && can) exp_ready[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (drain) begin
          rq_id.push_back(int'(rsp_id));
          rq_data.push_back(int'(rsp_data));
          rq_cyc.push_back(cyc);
          void'(mq.pop_front());
        end
        if (found && can) begin
          e.id   = w;
          e.res  = mshift(req_op[2*w +: 2], req_data[16*w +: 16], req_shamt[4*w +: 4]);
          e.gcyc = cyc;
          mq.push_back(e);
          m_rr = (w + 1) % NREQ;
          gq_id.push_back(w);
          gq_cyc.push_back(cyc);
        end
        gnt_seen = req_ready & req_valid;
      end
    end
  end

  task automatic present();
    for (int i = 0; i < NREQ; i++) begin
      if (hd[i] < tl[i]) begin
        req_valid[i]         = 1'b1;
        req_op[2*i +: 2]     = p_op[i][hd[i]];
        req_data[16*i +: 16] = p_data[i][hd[i]];
        req_shamt[4*i +: 4]  = p_sh[i][hd[i]];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic push_req(input int i, input logic [1:0] op, input logic [15:0] d,
                          input logic [3:0] s);
    p_op[i][tl[i]]   = op;
    p_data[i][tl[i]] = d;
    p_sh[i][tl[i]]   = s;
    tl[i]++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (gnt_seen[i]) hd[i]++;
    present();
  endtask

  function automatic bit idle();
    for (int i = 0; i < NREQ; i++) if (hd[i] < tl[i]) return 1'b0;
    return mq.size() == 0;
  endfunction

  task automatic wait_idle(input string nm, input int budget);
    for (int t = 0; t < budget; t++) begin
      if (idle()) break;
      tick();
    end
    checks++;
    if (!idle()) begin
      errors++;
      $display("FAIL %s_timeout: pipeline still busy after %0d cycles", nm, budget);
    end
  endtask

  task automatic clear_logs();
    gq_id.delete();
    gq_cyc.delete();
    rq_id.delete();
    rq_data.delete();
    rq_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hold_d;
    logic [IDW-1:0] hold_id;
    bit have;
    logic [15:0] allop_exp [8];

    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    req_valid = '0;
    req_op    = '0;
    req_data  = '0;
    req_shamt = '0;
    rsp_ready = 1'b1;

    // Reset values, with requests asserted to show req_ready is held low.
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness: all four requesters continuously valid.
    clear_logs();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < NREQ; i++)
        push_req(i, 2'(k + i), 16'h1357 * 16'(i + 1) ^ 16'(k << 8), 4'(3 * k + i));
    present();
    wait_idle("fair", 200);
    chk("fair_grants", 32'(gq_id.size()), 32'd16);
    for (int n = 0; n < 16; n++) begin
      chk("fair_gnt_order", 32'(gq_id[n]), 32'(n % 4));
      chk("fair_rsp_order", 32'(rq_id[n]), 32'(n % 4));
    end
    for (int n = 1; n < 16; n++) chk("fair_no_gap", 32'(rq_cyc[n] - rq_cyc[n-1]), 32'd1);

    // Single SRA request from requester 2.
    clear_logs();
    push_req(2, OP_SRA, 16'h8000, 4'd4);
    present();
    wait_idle("single", 50);
    chk("single_count", 32'(rq_id.size()), 32'd1);
    chk("single_data", 32'(rq_data[0]), 32'hF800);
    chk("single_id", 32'(rq_id[0]), 32'd2);
    chk("single_latency", 32'(rq_cyc[0] - gq_cyc[0]), 32'd2);

    // Wrap and skip: rr is now 3, only requesters 1 and 3 valid.
    clear_logs();
    push_req(1, OP_SLL, 16'h0001, 4'd15);
    push_req(3, OP_ROR, 16'h0001, 4'd1);
    present();
    wait_idle("wrap", 50);
    chk("wrap_first", 32'(gq_id[0]), 32'd3);
    chk("wrap_second", 32'(gq_id[1]), 32'd1);
    chk("wrap_sll_data", 32'(rq_data[1]), 32'h8000);
    chk("wrap_ror_data", 32'(rq_data[0]), 32'h8000);
    // rr should now be 2: with all valid the order is 2,3,0,1.
    clear_logs();
    for (int i = 0; i < NREQ; i++) push_req(i, OP_SRL, 16'hFFFF, 4'(i));
    present();
    wait_idle("wrap_rr", 50);
    for (int n = 0; n < 4; n++) chk("wrap_rr_order", 32'(gq_id[n]), 32'((n + 2) % 4));

    // All-op check from requester 1.
    clear_logs();
    for (int k = 0; k < 4; k++) push_req(1, 2'(k), 16'h8001, 4'd1);
    for (int k = 0; k < 4; k++) push_req(1, 2'(k), 16'h8001, 4'd0);
    allop_exp = '{16'h0002, 16'h4000, 16'hC000, 16'hC000,
                  16'h8001, 16'h8001, 16'h8001, 16'h8001};
    present();
    wait_idle("allop", 100);
    chk("allop_count", 32'(rq_data.size()), 32'd8);
    for (int n = 0; n < 8; n++) chk("allop_data", 32'(rq_data[n]), 32'(allop_exp[n]));

    // Backpressure: consumer stalls 5 cycles with three requesters active.
    clear_logs();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_req(i, OP_SLL, 16'h00F0 + 16'(i), 4'(i + 1));
      push_req(i, OP_SRA, 16'hF00F - 16'(i), 4'(i + 2));
    end
    present();
    have = 1'b0;
    hold_d = '0;
    hold_id = '0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (rsp_valid) begin
        if (!have) begin
          hold_d  = rsp_data;
          hold_id = rsp_id;
          have    = 1'b1;
        end else begin
          chk("bp_hold_data", 32'(rsp_data), 32'(hold_d));
          chk("bp_hold_id", 32'(rsp_id), 32'(hold_id));
        end
      end
    end
    chk("bp_grants", 32'(gq_id.size()), 32'd2);
    chk("bp_ready_low", 32'(req_ready), 32'h0);
    rsp_ready = 1'b1;
    wait_idle("bp", 100);
    chk("bp_drained", 32'(rq_id.size()), 32'd6);
    for (int n = 0; n < 6; n++) chk("bp_order", 32'(rq_id[n]), 32'(gq_id[n]));

    // Asynchronous reset with both stages full.
    clear_logs();
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      push_req(i, OP_ROR, 16'hA5C3 + 16'(i), 4'(i + 5));
      push_req(i, OP_SRL, 16'h3C5A + 16'(i), 4'(i + 7));
    end
    present();
    repeat (3) tick();
    chk("arst_full_valid", 32'(rsp_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    rsp_ready = 1'b1;
    wait_idle("arst", 100);
    chk("arst_first_grant", 32'(gq_id[0]), 32'd0);
    chk("arst_no_replay", 32'(rq_id.size()), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 16-bit shift datapath between NREQ independent requesters (e.g. ALU shift path, address-generation, debug port) using round-robin arbitration. Each request carries operand, shift amount and shift type. Results return on a single response channel tagged with the requester ID. It is a two-stage pipeline with valid/ready backpressure and sits between the issue logic and the shared shift resource in the execute stage.

## Interface
- NREQ, 4: number of requesters, 2..8
- IDW, 2: requester ID width, equal to clog2(NREQ)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_op  in  2*NREQ  per-requester op: 00 SLL, 01 SRL, 10 SRA, 11 ROR; requester i uses bits [2i+1:2i]
- req_data  in  16*NREQ  per-requester operand, slice i = [16i+15:16i]
- req_shamt  in  4*NREQ  per-requester shift amount 0..15
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  16  shifted result
- rsp_id  out  IDW  index of the originating requester

## Operation
- Stage A (operand register): holds op, data, shamt and id of the granted request, plus a valid bit a_v.
- Stage B (result register): holds the shifted value and id, with rsp_valid.
- Arbitration:
  - Round-robin pointer rr, reset 0.
  - The winner is the first requester with req_valid high, searching from rr upward and wrapping modulo NREQ.
  - A grant occurs only when stage A can accept: a_v==0, or stage A advances this cycle.
  - req_ready[winner]=1 in a grant cycle; all other bits are 0. req_ready is combinational from req_valid and pipeline state.
  - On a grant, rr becomes winner+1 mod NREQ. With no grant, rr holds.
- Stage advance:
  - B advances (is freed) when rsp_valid==0 or rsp_ready==1.
  - A advances into B when a_v==1 and B advances.
- Shift arithmetic (combinational between A and B):
  - SLL: data<<shamt, zero fill.
  - SRL: data>>shamt, zero fill.
  - SRA: sign fill from bit 15.
  - ROR: rotate right by shamt.
  - shamt==0 returns data unchanged for every op.
  - No width extension: results are truncated to 16 bits.
- No FSM beyond the two valid bits. Stage occupancy states are EMPTY, A-only, B-only and FULL. Transitions follow the advance rules above.
- A request with req_valid high but not granted must be held stable by the requester. The arbiter does not latch ungranted requests.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, a_v=0, rr=0.
- Latency: a request granted in cycle N produces rsp_valid in cycle N+2 if rsp_ready stays high.
- Throughput: one result per cycle under continuous requests and rsp_ready=1.
- Backpressure:
  - While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id are held stable.
  - When both stages are full, req_ready is all zero.
- Simultaneous events:
  - A grant into A, an A-to-B move and a B drain may all occur in the same cycle.
  - When full and rsp_ready=1, no bubble is inserted.
- Reset asserted mid-operation clears both stages immediately. In-flight requests are dropped and not replayed.
- rr wraps from NREQ-1 to 0.

## Structure
- Shared package `shift_pkg`:
  - Op encoding constants: OP_SLL, OP_SRL, OP_SRA, OP_ROR.
  - Typedef shift_op_t (2 bits).
  - Constant DATA_W=16 and SHAMT_W=4.
- Sub-module `shift_core`: purely combinational 16-bit four-op shifter (op, data, shamt -> result), instanced once between stage A and stage B.
- Round-robin winner selection is a function or always block inside shift_arbiter, not a separate module.

## Test plan
- Single request: requester 2 sends SRA data 0x8000, shamt 4, with rsp_ready=1. Required: rsp_valid two cycles after grant, rsp_data=0xF800, rsp_id=2.
- All-op check: data 0x8001, shamt 1. Required: SLL 0x0002, SRL 0x4000, SRA 0xC000, ROR 0xC000. With shamt 0, every op returns 0x8001.
- Fairness: all 4 requesters hold valid continuously with rsp_ready=1. Required: grant order 0,1,2,3,0,1,… and rsp_id follows the same sequence with no gaps.
- Backpressure: rsp_ready=0 for 5 cycles with 3 requesters active. Required:
  - Exactly 2 grants occur, then req_ready stays 0.
  - rsp_data/rsp_id stay stable.
  - After release, results drain in grant order with no loss or duplication.
- Wrap and skip: rr=3 and only requesters 1 and 3 are valid. Required: grant 3, then grant 1, then rr=2.
- Async reset: assert rst_n low while both stages are full. Required:
  - rsp_valid=0 and req_ready=0 immediately, with no clock edge needed.
  - After release, the first grant goes to requester 0 when all are valid.
